// File: rtl/divider_pkg.sv
// Shared types and defaults for the sequential divider.
// The divider top is configured by the DIV_ZERO_DETECT_EN macro.
package divider_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam int DW_DEF = 8;
    localparam int VW_DEF = 4;
    localparam int CNT_W  = $clog2(DW_DEF + 1);

    // Counter width able to hold the value dw.
    function automatic int cnt_width(input int dw);
        return $clog2(dw + 1);
    endfunction

endpackage

// File: rtl/sequential_divider_div_step.sv
// One restoring-division iteration: shift in a dividend bit,
// compare against the divisor and conditionally subtract.
module div_step #(
    parameter int VW = 4
) (
    input  logic [VW-1:0] rem,
    input  logic          in_bit,
    input  logic [VW-1:0] divisor,
    output logic [VW-1:0] rem_next,
    output logic          q_bit
);

    logic [VW:0]   t;
    logic [VW+1:0] diff;
    logic          borrow;

    // Borrow out of the widened subtract means t < divisor.
    always_comb begin
        t        = {rem, in_bit};
        diff     = {1'b0, t} - {2'b00, divisor};
        borrow   = diff[VW+1];
        q_bit    = ~borrow;
        rem_next = borrow ? t[VW-1:0] : diff[VW-1:0];
    end

endmodule

// File: rtl/sequential_divider.sv
// Multi-cycle unsigned restoring divider, one quotient bit per clock.
// Define DIV_ZERO_DETECT_EN to short-cut and flag divide-by-zero.
module sequential_divider
    import divider_pkg::*;
#(
    parameter int DW = DW_DEF,
    parameter int VW = VW_DEF
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [DW-1:0] dividend,
    input  logic [VW-1:0] divisor,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [DW-1:0] quotient,
    output logic [VW-1:0] remainder,
    output logic          div_zero
);

    localparam int CW = cnt_width(DW);

    state_t        state;
    state_t        state_nxt;
    logic [CW-1:0] count;
    logic [DW-1:0] dvd;
    logic [VW-1:0] dsr;
    logic          zero_op;
    logic          is_zero;
    logic [VW-1:0] rem_nxt;
    logic          q_bit;

`ifdef DIV_ZERO_DETECT_EN
    assign is_zero = (divisor == '0);
`else
    assign is_zero = 1'b0;
`endif

    assign in_ready  = (state == IDLE);
    assign out_valid = (state == DONE);

    div_step #(
        .VW(VW)
    ) u_step (
        .rem     (remainder),
        .in_bit  (dvd[DW-1]),
        .divisor (dsr),
        .rem_next(rem_nxt),
        .q_bit   (q_bit)
    );

    // State register.
    always_ff @(posedge clk) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    // Next-state logic; BUSY ends on the edge that drains count.
    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE:    if (in_valid) state_nxt = BUSY;
            BUSY:    if (count == CW'(1)) state_nxt = DONE;
            DONE:    if (out_ready) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Datapath: load on accept, iterate in BUSY, hold in DONE.
    // A zero divisor under detection spends one BUSY cycle that
    // loads the fixed result instead of iterating.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            count     <= '0;
            dvd       <= '0;
            dsr       <= '0;
            zero_op   <= 1'b0;
            quotient  <= '0;
            remainder <= '0;
            div_zero  <= 1'b0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (in_valid) begin
                        dvd       <= dividend;
                        dsr       <= divisor;
                        remainder <= '0;
                        zero_op   <= is_zero;
                        div_zero  <= is_zero;
                        count     <= is_zero ? CW'(1) : CW'(DW);
                    end
                end
                BUSY: begin
                    count <= count - 1'b1;
                    if (zero_op) begin
                        quotient  <= '1;
                        remainder <= dvd[VW-1:0];
                    end else begin
                        dvd       <= {dvd[DW-2:0], 1'b0};
                        remainder <= rem_nxt;
                        quotient  <= {quotient[DW-2:0], q_bit};
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule
